// File: rtl/mdio_pkg.sv
// mdio_pkg
//   Shared definitions for the Clause-22 MDIO master: opcode constants,
//   frame field widths, the frame FSM state encoding and two small helpers
//   that describe the field sequence (length of each field and its successor).
package mdio_pkg;

  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;

  localparam int MDIO_ST_W      = 2;
  localparam int MDIO_OP_W      = 2;
  localparam int MDIO_ADDR_W    = 5;
  localparam int MDIO_TA_W      = 2;
  localparam int MDIO_DATA_W    = 16;
  localparam int MDIO_FRAME_W   = 32;  // ST..DATA, everything after the preamble
  localparam int MDIO_BIT_CNT_W = 8;   // bit-within-field counter, also covers the preamble

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_PRE   = 4'd1,
    S_ST    = 4'd2,
    S_OP    = 4'd3,
    S_PHYAD = 4'd4,
    S_REGAD = 4'd5,
    S_TA    = 4'd6,
    S_DATA  = 4'd7,
    S_DONE  = 4'd8
  } mdio_state_t;

  // Number of bits in a fixed-length field (the preamble length is a
  // parameter of the controller and is handled there).
  function automatic logic [MDIO_BIT_CNT_W-1:0] mdio_field_len(input mdio_state_t s);
    case (s)
      S_ST:    return MDIO_BIT_CNT_W'(MDIO_ST_W);
      S_OP:    return MDIO_BIT_CNT_W'(MDIO_OP_W);
      S_PHYAD: return MDIO_BIT_CNT_W'(MDIO_ADDR_W);
      S_REGAD: return MDIO_BIT_CNT_W'(MDIO_ADDR_W);
      S_TA:    return MDIO_BIT_CNT_W'(MDIO_TA_W);
      S_DATA:  return MDIO_BIT_CNT_W'(MDIO_DATA_W);
      default: return MDIO_BIT_CNT_W'(1);
    endcase
  endfunction

  function automatic mdio_state_t mdio_next_field(input mdio_state_t s);
    case (s)
      S_PRE:   return S_ST;
      S_ST:    return S_OP;
      S_OP:    return S_PHYAD;
      S_PHYAD: return S_REGAD;
      S_REGAD: return S_TA;
      S_TA:    return S_DATA;
      S_DATA:  return S_DONE;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// mdio_clk_gen
//   MDC generator. On i_load the divisor is captured (clamped to >= 2) and
//   MDC restarts low; while i_run is high MDC toggles every r_div cycles, so
//   the first rising edge comes r_div cycles after the load.
//   Ports:
//     i_clk, i_rst_n   clock, synchronous active-low reset
//     i_load           capture i_clk_div and restart the divider
//     i_run            divider runs; when low MDC is held low
//     i_clk_div        MDC half-period in i_clk cycles
//     o_mdc            MDIO clock
//     o_rise / o_fall  high in the cycle whose closing edge raises / drops MDC
module mdio_clk_gen #(
  parameter int CLK_DIV_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_load,
  input  logic                     i_run,
  input  logic [CLK_DIV_WIDTH-1:0] i_clk_div,
  output logic                     o_mdc,
  output logic                     o_rise,
  output logic                     o_fall
);

  logic [CLK_DIV_WIDTH-1:0] r_div;
  logic [CLK_DIV_WIDTH-1:0] r_cnt;
  logic                     r_mdc;
  logic                     w_wrap;

  assign w_wrap = i_run && (r_cnt == (r_div - CLK_DIV_WIDTH'(1)));
  assign o_rise = w_wrap && !r_mdc;
  assign o_fall = w_wrap &&  r_mdc;
  assign o_mdc  = r_mdc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_div <= CLK_DIV_WIDTH'(2);
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else if (i_load) begin
      r_div <= (i_clk_div < CLK_DIV_WIDTH'(2)) ? CLK_DIV_WIDTH'(2) : i_clk_div;
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else if (!i_run) begin
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_mdc <= ~r_mdc;
    end else begin
      r_cnt <= r_cnt + CLK_DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mdio_master_ctrl.sv
// mdio_master_ctrl
//   Clause-22 MDIO master. Sends PRE (PREAMBLE_LEN ones), ST, OP, PHYAD,
//   REGAD, TA and DATA, MSB first, on mdio_o/mdio_t, and for reads shifts
//   mdio_i into rd_data.
//   Optional build macro: MDIO_PREAMBLE_SUPPRESS_EN adds input cmd_no_pre;
//   a frame started with cmd_no_pre=1 skips the preamble.
//   Ports:
//     s_axi_aclk, s_axi_aresetn   clock, synchronous active-low reset
//     cmd_start/op/phy_addr/reg_addr/wr_data, clk_div   command, captured on accept
//     mdc, mdio_o, mdio_t, mdio_i MDIO pins (mdio_t=1 releases the line)
//     busy, done, rd_data, rd_err, cmd_err   status
//     o_dbg_state                 current frame FSM state (mdio_state_t encoding)
//
//   Handshake: cmd_start is a one-cycle valid; busy=0 acts as ready. A start
//   seen while busy is dropped silently; a start with an opcode other than
//   read/write is refused with a cmd_err pulse in the following cycle.
module mdio_master_ctrl
  import mdio_pkg::*;
#(
  parameter int CLK_DIV_WIDTH = 8,
  parameter int PREAMBLE_LEN  = 32
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  input  logic                     cmd_start,
  input  logic [MDIO_OP_W-1:0]     cmd_op,
  input  logic [MDIO_ADDR_W-1:0]   cmd_phy_addr,
  input  logic [MDIO_ADDR_W-1:0]   cmd_reg_addr,
  input  logic [MDIO_DATA_W-1:0]   cmd_wr_data,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  input  logic                     cmd_no_pre,
`endif
  input  logic [CLK_DIV_WIDTH-1:0] clk_div,
  output logic                     mdc,
  output logic                     mdio_o,
  output logic                     mdio_t,
  input  logic                     mdio_i,
  output logic                     busy,
  output logic                     done,
  output logic [MDIO_DATA_W-1:0]   rd_data,
  output logic                     rd_err,
  output logic                     cmd_err,
  output logic [3:0]               o_dbg_state
);

  mdio_state_t               r_state, w_state_next;
  logic [MDIO_BIT_CNT_W-1:0] r_bit, w_bit_next, w_field_last;
  logic [MDIO_FRAME_W-1:0]   r_tx, w_tx_src, w_frame_new;
  logic [MDIO_DATA_W-1:0]    r_rx, r_rd_data;
  logic r_is_rd, r_mdio_o, r_mdio_t, r_rd_err, r_cmd_err;
  logic w_op_ok, w_cmd_rd, w_idle, w_accept, w_reject, w_run, w_no_pre;
  logic w_is_rd_src, w_rise, w_fall;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign w_no_pre = cmd_no_pre;
`else
  assign w_no_pre = 1'b0;
`endif

  assign w_idle   = (r_state == S_IDLE);
  assign w_cmd_rd = (cmd_op == MDIO_OP_RD);
  assign w_op_ok  = (cmd_op == MDIO_OP_WR) || w_cmd_rd;
  assign w_accept = cmd_start && w_idle && w_op_ok;
  assign w_reject = cmd_start && w_idle && !w_op_ok;
  assign w_run    = !w_idle && (r_state != S_DONE);

  // Everything after the preamble. A read leaves TA/DATA as ones; mdio_t is
  // released there so those bits never reach the line.
  assign w_frame_new = {2'b01, cmd_op, cmd_phy_addr, cmd_reg_addr,
                        w_cmd_rd ? 2'b11 : 2'b10,
                        w_cmd_rd ? 16'hFFFF : cmd_wr_data};

  // On the accept edge the first bit comes from the inputs, not from r_tx.
  assign w_tx_src    = w_accept ? w_frame_new : r_tx;
  assign w_is_rd_src = w_accept ? w_cmd_rd : r_is_rd;

  assign w_field_last = (r_state == S_PRE) ? MDIO_BIT_CNT_W'(PREAMBLE_LEN - 1)
                                           : mdio_field_len(r_state) - MDIO_BIT_CNT_W'(1);

  mdio_clk_gen #(.CLK_DIV_WIDTH(CLK_DIV_WIDTH)) u_clk_gen (
    .i_clk     (s_axi_aclk),
    .i_rst_n   (s_axi_aresetn),
    .i_load    (w_accept),
    .i_run     (w_run),
    .i_clk_div (clk_div),
    .o_mdc     (mdc),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_state <= S_IDLE;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_next;
      r_bit   <= w_bit_next;
    end
  end

  // Bits advance on MDC falling edges; DONE lasts exactly one cycle.
  always_comb begin
    w_state_next = r_state;
    w_bit_next   = r_bit;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_no_pre ? S_ST : S_PRE;
          w_bit_next   = '0;
        end
      end
      S_DONE: w_state_next = S_IDLE;
      default: begin
        if (w_fall) begin
          if (r_bit == w_field_last) begin
            w_state_next = mdio_next_field(r_state);
            w_bit_next   = '0;
          end else begin
            w_bit_next = r_bit + MDIO_BIT_CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      r_tx      <= '0;
      r_rx      <= '0;
      r_is_rd   <= 1'b0;
      r_mdio_o  <= 1'b1;
      r_mdio_t  <= 1'b1;
      r_rd_data <= '0;
      r_rd_err  <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= w_reject;
      if (w_accept) begin
        r_is_rd  <= w_cmd_rd;
        r_rd_err <= 1'b0;
      end
      // New bit on the line at accept and at every MDC fall.
      if (w_accept || w_fall) begin
        case (w_state_next)
          S_PRE: begin
            r_mdio_o <= 1'b1;
            r_mdio_t <= 1'b0;
            r_tx     <= w_tx_src;
          end
          S_DONE: begin
            r_mdio_o <= 1'b1;
            r_mdio_t <= 1'b1;
          end
          default: begin
            r_mdio_o <= w_tx_src[MDIO_FRAME_W-1];
            r_tx     <= {w_tx_src[MDIO_FRAME_W-2:0], 1'b0};
            r_mdio_t <= w_is_rd_src && ((w_state_next == S_TA) || (w_state_next == S_DATA));
          end
        endcase
      end
      // A PHY must drive the second TA bit low; a one means nobody answered.
      if (w_rise && r_is_rd && (r_state == S_TA) && (r_bit == MDIO_BIT_CNT_W'(1)))
        r_rd_err <= mdio_i;
      if (w_rise && (r_state == S_DATA))
        r_rx <= {r_rx[MDIO_DATA_W-2:0], mdio_i};
      if (r_is_rd && (r_state == S_DATA) && (w_state_next == S_DONE))
        r_rd_data <= r_rx;
    end
  end

  assign mdio_o      = r_mdio_o;
  assign mdio_t      = r_mdio_t;
  assign busy        = !w_idle;
  assign done        = (r_state == S_DONE);
  assign rd_data     = r_rd_data;
  assign rd_err      = r_rd_err;
  assign cmd_err     = r_cmd_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mdio_master_ctrl.sv
module tb_mdio_master_ctrl;
  import mdio_pkg::*;

  localparam int P = 32;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        s_axi_aresetn;
  logic        cmd_start;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_wr_data;
  logic        cmd_no_pre;
  logic [7:0]  clk_div;
  logic        mdc, mdio_o, mdio_t, mdio_i;
  logic        busy, done, rd_err, cmd_err;
  logic [15:0] rd_data;
  logic [3:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  mdio_master_ctrl #(.CLK_DIV_WIDTH(8), .PREAMBLE_LEN(P)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (s_axi_aresetn),
    .cmd_start     (cmd_start),
    .cmd_op        (cmd_op),
    .cmd_phy_addr  (cmd_phy_addr),
    .cmd_reg_addr  (cmd_reg_addr),
    .cmd_wr_data   (cmd_wr_data),
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    .cmd_no_pre    (cmd_no_pre),
`endif
    .clk_div       (clk_div),
    .mdc           (mdc),
    .mdio_o        (mdio_o),
    .mdio_t        (mdio_t),
    .mdio_i        (mdio_i),
    .busy          (busy),
    .done          (done),
    .rd_data       (rd_data),
    .rd_err        (rd_err),
    .cmd_err       (cmd_err),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- line monitor + PHY model ----------------
  // Records {mdio_t, mdio_o} at every MDC rise, with its cycle number; the
  // PHY presents bit k+1 right after it has seen rise k.
  logic [1:0] obs_q[$];
  int         rise_q[$];
  logic       phy_vec [0:127];
  int         obs_base = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         err_cnt  = 0;
  logic       prev_mdc = 1'b0;

  always @(negedge clk) begin
    int idx;
    if (mdc && !prev_mdc) begin
      obs_q.push_back({mdio_t, mdio_o});
      rise_q.push_back(cyc);
    end
    prev_mdc = mdc;
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (cmd_err) err_cnt = err_cnt + 1;
    idx = obs_q.size() - obs_base;
    mdio_i = (idx >= 0 && idx < 128) ? phy_vec[idx] : 1'b1;
  end

  logic [15:0] last_rd;

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    s_axi_aresetn = 1'b0;
    repeat (4) @(negedge clk);
    s_axi_aresetn = 1'b1;
    @(negedge clk);
  endtask

  // Runs one frame and checks it against a bit-level expectation built from
  // the field values.
  task automatic run_frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] rg,
                           input logic [15:0] data, input int div, input bit no_pre,
                           input logic ta_bit, input bit disturb, input string name);
    logic [1:0] exp_q[$];
    int d, n, base, t0, db, ob, eb, mism, tmis, lmis, k, got;
    bit is_rd;
    logic exp_err;
    d     = (div < 2) ? 2 : div;
    is_rd = (op == MDIO_OP_RD);
    base  = no_pre ? 0 : P;
    if (!no_pre) for (int j = 0; j < P; j++) exp_q.push_back(2'b01);
    exp_q.push_back(2'b00); exp_q.push_back(2'b01);
    for (int j = 1; j >= 0; j--) exp_q.push_back({1'b0, op[j]});
    for (int j = 4; j >= 0; j--) exp_q.push_back({1'b0, phy[j]});
    for (int j = 4; j >= 0; j--) exp_q.push_back({1'b0, rg[j]});
    if (is_rd) begin exp_q.push_back(2'b10); exp_q.push_back(2'b10); end
    else       begin exp_q.push_back(2'b01); exp_q.push_back(2'b00); end
    for (int j = 15; j >= 0; j--) exp_q.push_back(is_rd ? 2'b10 : {1'b0, data[j]});
    n = exp_q.size();
    for (int j = 0; j < 128; j++) phy_vec[j] = 1'b1;
    if (is_rd) begin
      phy_vec[base + 15] = ta_bit;
      for (int j = 0; j < 16; j++) phy_vec[base + 16 + j] = data[15 - j];
    end
    exp_err = is_rd ? ta_bit : 1'b0;

    @(negedge clk);
    ob = obs_q.size(); db = done_cnt; eb = err_cnt; obs_base = ob;
    cmd_op = op; cmd_phy_addr = phy; cmd_reg_addr = rg; cmd_wr_data = data;
    clk_div = 8'(div); cmd_no_pre = no_pre; cmd_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    cmd_start = 1'b0;
    for (int i = 0; i < 2 * n * d + 40 && done_cnt == db; i++) begin
      @(negedge clk);
      if (disturb && i == 40) begin
        cmd_start = 1'b1; cmd_op = ($urandom_range(0, 1) == 0) ? MDIO_OP_WR : MDIO_OP_RD;
        cmd_phy_addr = 5'($urandom); cmd_reg_addr = 5'($urandom);
        cmd_wr_data = 16'($urandom); clk_div = 8'd0; cmd_no_pre = 1'b1;
      end
      if (disturb && i == 41) cmd_start = 1'b0;
    end
    repeat (3) @(negedge clk);

    n_tests++;
    if (done_cnt - db !== 1) begin
      n_fail++; $display("FAIL %s done_pulses got=%0d exp=1", name, done_cnt - db);
    end
    n_tests++;
    if (done_cyc !== t0 + 1 + 2 * n * d) begin
      n_fail++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_cyc - t0, 1 + 2 * n * d);
    end
    got = obs_q.size() - ob;
    n_tests++;
    if (got !== n) begin
      n_fail++; $display("FAIL %s mdc_periods got=%0d exp=%0d", name, got, n);
    end
    mism = 0; tmis = 0; lmis = 0;
    for (k = 0; k < n && k < got; k++) begin
      if (obs_q[ob + k][1] !== exp_q[k][1]) tmis++;
      if (exp_q[k][1] == 1'b0 && obs_q[ob + k][0] !== exp_q[k][0]) mism++;
      if (rise_q[ob + k] !== t0 + 1 + (2 * k + 1) * d) lmis++;
    end
    n_tests++;
    if (mism != 0) begin
      n_fail++; $display("FAIL %s mdio_o_bits got=%0d wrong bits exp=0", name, mism);
    end
    n_tests++;
    if (tmis != 0) begin
      n_fail++; $display("FAIL %s mdio_t_bits got=%0d wrong bits exp=0", name, tmis);
    end
    n_tests++;
    if (lmis != 0) begin
      n_fail++; $display("FAIL %s mdc_rise_timing got=%0d late/early rises exp=0", name, lmis);
    end
    n_tests++;
    if ({busy, mdc, mdio_t} !== 3'b001) begin
      n_fail++; $display("FAIL %s idle_after got busy/mdc/mdio_t=%b exp=001", name, {busy, mdc, mdio_t});
    end
    if (is_rd) last_rd = data;
    n_tests++;
    if (rd_data !== last_rd) begin
      n_fail++; $display("FAIL %s rd_data got=%h exp=%h", name, rd_data, last_rd);
    end
    n_tests++;
    if (rd_err !== exp_err) begin
      n_fail++; $display("FAIL %s rd_err got=%b exp=%b", name, rd_err, exp_err);
    end
    n_tests++;
    if (err_cnt - eb !== 0) begin
      n_fail++; $display("FAIL %s cmd_err_during_frame got=%0d exp=0", name, err_cnt - eb);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    last_rd = 16'h0000;
    n_tests++;
    if ({mdc, mdio_o, mdio_t, busy, done, cmd_err, rd_err} !== 7'b0110000) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=0110000", {mdc, mdio_o, mdio_t, busy, done, cmd_err, rd_err});
    end
    n_tests++;
    if (rd_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data);
    end
  endtask

  task automatic test_write_vector();
    run_frame(MDIO_OP_WR, 5'h01, 5'h00, 16'h1140, 4, 1'b0, 1'b0, 1'b0, "write_1140");
  endtask

  task automatic test_read_vector();
    run_frame(MDIO_OP_RD, 5'h03, 5'h02, 16'h0141, 4, 1'b0, 1'b0, 1'b0, "read_0141");
  endtask

  task automatic test_read_no_phy();
    run_frame(MDIO_OP_RD, 5'h03, 5'h02, 16'hFFFF, 3, 1'b0, 1'b1, 1'b0, "read_no_phy");
  endtask

  task automatic test_cmd_err();
    logic [1:0] bad [2];
    bad[0] = 2'b11; bad[1] = 2'b00;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      cmd_op = bad[j]; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      n_tests++;
      if ({cmd_err, busy} !== 2'b10) begin
        n_fail++; $display("FAIL cmd_err_pulse op=%b got cmd_err/busy=%b exp=10", bad[j], {cmd_err, busy});
      end
      @(negedge clk);
      n_tests++;
      if ({cmd_err, busy} !== 2'b00) begin
        n_fail++; $display("FAIL cmd_err_width op=%b got cmd_err/busy=%b exp=00", bad[j], {cmd_err, busy});
      end
    end
  endtask

  task automatic test_ignore_midframe();
    run_frame(MDIO_OP_WR, 5'h0A, 5'h15, 16'hA5C3, 3, 1'b0, 1'b0, 1'b1, "ignore_midframe");
  endtask

  task automatic test_reset_midframe();
    int ob, db, i;
    for (int j = 0; j < 128; j++) phy_vec[j] = 1'b1;
    phy_vec[P + 15] = 1'b0;
    for (int j = 0; j < 16; j++) phy_vec[P + 16 + j] = j[0];
    @(negedge clk);
    ob = obs_q.size(); db = done_cnt; obs_base = ob;
    cmd_op = MDIO_OP_RD; cmd_phy_addr = 5'h03; cmd_reg_addr = 5'h02;
    clk_div = 8'd3; cmd_no_pre = 1'b0; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    // Wait until data bit 7 has been clocked (its MDC rise seen).
    for (i = 0; i < 2000 && obs_q.size() - ob < P + 16 + 8; i++) @(negedge clk);
    n_tests++;
    if (obs_q.size() - ob < P + 16 + 8) begin
      n_fail++; $display("FAIL rst_mid_reach got=%0d rises exp=%0d", obs_q.size() - ob, P + 24);
    end
    s_axi_aresetn = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mdc, mdio_t, busy, done} !== 4'b0100) begin
      n_fail++; $display("FAIL rst_mid_state got mdc/mdio_t/busy/done=%b exp=0100", {mdc, mdio_t, busy, done});
    end
    s_axi_aresetn = 1'b1;
    repeat (20) @(negedge clk);
    last_rd = 16'h0000;
    n_tests++;
    if (done_cnt - db !== 0) begin
      n_fail++; $display("FAIL rst_mid_no_done got=%0d exp=0", done_cnt - db);
    end
    n_tests++;
    if ({rd_data, rd_err, busy} !== 18'h0) begin
      n_fail++; $display("FAIL rst_mid_status got rd_data=%h rd_err=%b busy=%b exp=0", rd_data, rd_err, busy);
    end
    run_frame(MDIO_OP_WR, 5'h1F, 5'h1F, 16'h8001, 2, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_clk_div_clamp();
    run_frame(MDIO_OP_WR, 5'h04, 5'h09, 16'h3C3C, 0, 1'b0, 1'b0, 1'b0, "clk_div0");
    run_frame(MDIO_OP_RD, 5'h11, 5'h06, 16'h5AA5, 1, 1'b0, 1'b0, 1'b0, "clk_div1");
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++) begin
      logic [1:0] op;
      op = ($urandom_range(0, 1) == 0) ? MDIO_OP_WR : MDIO_OP_RD;
      run_frame(op, 5'($urandom), 5'($urandom), 16'($urandom), $urandom_range(0, 5), 1'b0,
                ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_frame(MDIO_OP_RD, 5'h07, 5'h01, 16'hBEEF, 2, 1'b0, 1'b0, 1'b0, "b2b_rd");
    run_frame(MDIO_OP_WR, 5'h07, 5'h01, 16'h0F0F, 2, 1'b0, 1'b0, 1'b0, "b2b_wr_holds_rd");
  endtask

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  task automatic test_no_pre();
    run_frame(MDIO_OP_WR, 5'h02, 5'h03, 16'h1234, 0, 1'b1, 1'b0, 1'b0, "no_pre_wr");
    run_frame(MDIO_OP_RD, 5'h02, 5'h03, 16'h4321, 2, 1'b1, 1'b0, 1'b0, "no_pre_rd");
  endtask
`endif

  initial begin
    s_axi_aresetn = 1'b0; cmd_start = 1'b0; cmd_op = 2'b00;
    cmd_phy_addr = '0; cmd_reg_addr = '0; cmd_wr_data = '0;
    cmd_no_pre = 1'b0; clk_div = 8'd4; last_rd = 16'h0000;
    for (int j = 0; j < 128; j++) phy_vec[j] = 1'b1;
    test_reset();
    test_write_vector();
    test_read_vector();
    test_read_no_phy();
    test_cmd_err();
    test_ignore_midframe();
    test_reset_midframe();
    test_clk_div_clamp();
    test_back_to_back();
    test_random();
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    test_no_pre();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
